collision_checker: RTL

COLLISION_CHECKER -- requirements
Module: collision_checker

---
 rtl/collision_checker.sv | 117 +++++++++++
 1 files changed

// File: rtl/collision_checker.sv
// Player/object collision judge: turns lane-aligned objects on frame ticks into
// died / got_powerup pulses, tracks post-death invulnerability and a hit count.
module collision_checker #(
    parameter int INVULN_FRAMES = 60,
    parameter int ID_WIDTH      = 4
) (
    input  logic                clk_in,
    input  logic                rst_in_n,
    input  logic                playing,
    input  logic                frame_tick,
    input  logic [1:0]          player_lane,
    input  logic                jump,
    input  logic                obj_valid,
    input  logic [1:0]          obj_lane,
    input  logic [1:0]          obj_kind,
    input  logic [ID_WIDTH-1:0] obj_id,
    output logic                died,
    output logic                got_powerup,
    output logic                invuln,
    output logic [7:0]          hits
);

    localparam int CNT_W = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INVULN_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_INVULN
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ID_WIDTH-1:0]   r_last_id;
    logic                  r_last_vld;
    logic                  r_died;
    logic                  r_powerup;
    logic                  r_invuln;
    logic [7:0]            r_hits;

    logic w_eval;
    logic w_damaging;
    logic w_is_powerup;
    logic w_protected;

    // An object is judged once per id: repeats of the last consumed id are skipped.
    assign w_eval = playing && frame_tick && (r_state != S_IDLE) && obj_valid &&
                    (obj_lane == player_lane) &&
                    (!r_last_vld || (obj_id != r_last_id));
    assign w_damaging   = (obj_kind == 2'b10) || ((obj_kind == 2'b01) && !jump);
    assign w_is_powerup = (obj_kind == 2'b11);
    // Judged on the current state, so the tick that ends INVULN still ignores hits.
    assign w_protected  = (r_state == S_INVULN);

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_last_id  <= '0;
            r_last_vld <= 1'b0;
            r_died     <= 1'b0;
            r_powerup  <= 1'b0;
            r_invuln   <= 1'b0;
            r_hits     <= 8'd0;
        end else begin
            r_died    <= 1'b0;
            r_powerup <= 1'b0;
            if (!playing) begin
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_last_vld <= 1'b0;
                r_invuln   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state  <= S_ARMED;
                        r_hits   <= 8'd0;
                        r_invuln <= 1'b0;
                    end
                    default: begin
                        if ((r_state == S_INVULN) && frame_tick) begin
                            r_cnt <= r_cnt - CNT_ONE;
                            if (r_cnt == CNT_ONE) begin
                                r_state  <= S_ARMED;
                                r_invuln <= 1'b0;
                            end
                        end
                        if (w_eval) begin
                            r_last_id  <= obj_id;
                            r_last_vld <= 1'b1;
                            if (w_is_powerup) begin
                                r_powerup <= 1'b1;
                            end else if (w_damaging && !w_protected) begin
                                r_died <= 1'b1;
                                if (r_hits != 8'hFF) begin
                                    r_hits <= r_hits + 8'd1;
                                end
                                if (INVULN_FRAMES > 0) begin
                                    r_state  <= S_INVULN;
                                    r_cnt    <= CNT_LOAD;
                                    r_invuln <= 1'b1;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign died        = r_died;
    assign got_powerup = r_powerup;
    assign invuln      = r_invuln;
    assign hits        = r_hits;

endmodule
